// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state micro-sequencer that turns one opcode into
// register-load / bus-enable strobes for an A/B accumulator datapath.
// Ports: clk, rst (async, active high), start, opcode[OPW-1:0], cf_in, zf_in
//   -> nLa, nLb (active low), Ea, Eu, sub, busy, done, illegal, cf_q, zf_q,
//      op_count[7:0] (completed instructions, wraps).
module alu_sequencer #(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           cf_in,
  input  logic           zf_in,
  output logic           nLa,
  output logic           nLb,
  output logic           Ea,
  output logic           Eu,
  output logic           sub,
  output logic           busy,
  output logic           done,
  output logic           illegal,
  output logic           cf_q,
  output logic           zf_q,
  output logic [7:0]     op_count
);

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_LDB = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4);
  localparam logic [OPW-1:0] OP_OUT = OPW'(5);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] opc_q, opc_d;
  logic           illegal_q, illegal_d;
  logic           cf_d, zf_d;
  logic [7:0]     op_count_q, op_count_d;
  logic           is_arith;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      opc_q      <= '0;
      illegal_q  <= 1'b0;
      cf_q       <= 1'b0;
      zf_q       <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      illegal_q  <= illegal_d;
      cf_q       <= cf_d;
      zf_q       <= zf_d;
      op_count_q <= op_count_d;
    end
  end

  assign is_arith = (opc_q == OP_ADD) || (opc_q == OP_SUB);

  // Next-state and datapath-side bookkeeping
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    illegal_d  = illegal_q;
    cf_d       = cf_q;
    zf_d       = zf_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opc_d   = opcode;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // 110/111 both have the MSB pair set
        if (opc_q[OPW-1] && opc_q[OPW-2])
          illegal_d = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        if (is_arith) begin
          cf_d = cf_in;
          zf_d = zf_in;
        end
        state_d = DONE;
      end
      DONE: begin
        op_count_d = op_count_q + 8'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode only registered state, so reset clears them at once
  always_comb begin
    nLa = 1'b1;
    nLb = 1'b1;
    Ea  = 1'b0;
    Eu  = 1'b0;
    sub = 1'b0;
    if (state_q == EXEC) begin
      case (opc_q)
        OP_LDA: nLa = 1'b0;
        OP_LDB: nLb = 1'b0;
        OP_ADD: begin
          Eu  = 1'b1;
          nLa = 1'b0;
        end
        OP_SUB: begin
          Eu  = 1'b1;
          nLa = 1'b0;
          sub = 1'b1;
        end
        OP_OUT: Ea = 1'b1;
        OP_NOP: ;
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign illegal  = illegal_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] opcode;
  logic       cf_in, zf_in;
  logic       nLa, nLb, Ea, Eu, sub;
  logic       busy, done, illegal;
  logic       cf_q, zf_q;
  logic [7:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer #(.OPW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .cf_in(cf_in), .zf_in(zf_in),
    .nLa(nLa), .nLb(nLb), .Ea(Ea), .Eu(Eu), .sub(sub),
    .busy(busy), .done(done), .illegal(illegal),
    .cf_q(cf_q), .zf_q(zf_q), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packs controls as {nLa,nLb,Ea,Eu,sub}
  function automatic logic [4:0] ctl();
    return {nLa, nLb, Ea, Eu, sub};
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; opcode = 3'b000;
    cf_in = 1'b0; zf_in = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = 3'b000;
    cf_in = 1'b0; zf_in = 1'b0;
    #2;
    n_cmp++;
    if (ctl() !== 5'b11000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 11000", ctl());
    end
    n_cmp++;
    if ({busy, done, illegal, cf_q, zf_q, op_count} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_status: got %b%b%b%b%b cnt=%0d want zeros",
               busy, done, illegal, cf_q, zf_q, op_count);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_lda();
    start = 1'b1; opcode = 3'b001;
    step();
    start = 1'b0; opcode = 3'b000;
    n_cmp++;
    if (busy !== 1'b1 || nLa !== 1'b1) begin
      n_bad++;
      $display("FAIL lda_decode: busy=%b nLa=%b want 1 1", busy, nLa);
    end
    step();
    n_cmp++;
    if (ctl() !== 5'b01000) begin
      n_bad++;
      $display("FAIL lda_exec: got %b want 01000", ctl());
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || ctl() !== 5'b11000) begin
      n_bad++;
      $display("FAIL lda_done: done=%b ctl=%b want 1 11000", done, ctl());
    end
    step();
    n_cmp++;
    if (op_count !== 8'd1 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL lda_count: cnt=%0d done=%b busy=%b want 1 0 0",
               op_count, done, busy);
    end
  endtask

  task automatic test_sub_out();
    start = 1'b1; opcode = 3'b100;
    step();
    start = 1'b0;
    step();
    cf_in = 1'b1; zf_in = 1'b1;
    n_cmp++;
    if (ctl() !== 5'b01011) begin
      n_bad++;
      $display("FAIL sub_exec: got %b want 01011", ctl());
    end
    step();
    cf_in = 1'b0; zf_in = 1'b0;
    n_cmp++;
    if (cf_q !== 1'b1 || zf_q !== 1'b1) begin
      n_bad++;
      $display("FAIL sub_flags: cf=%b zf=%b want 1 1", cf_q, zf_q);
    end
    step();
    start = 1'b1; opcode = 3'b101;
    step();
    start = 1'b0;
    step();
    n_cmp++;
    if (ctl() !== 5'b11100) begin
      n_bad++;
      $display("FAIL out_exec: got %b want 11100", ctl());
    end
    step();
    step();
    n_cmp++;
    if (cf_q !== 1'b1 || zf_q !== 1'b1 || op_count !== 8'd3) begin
      n_bad++;
      $display("FAIL out_hold: cf=%b zf=%b cnt=%0d want 1 1 3",
               cf_q, zf_q, op_count);
    end
  endtask

  task automatic test_illegal();
    start = 1'b1; opcode = 3'b110;
    step();
    start = 1'b0;
    step();
    n_cmp++;
    if (ctl() !== 5'b11000 || illegal !== 1'b1) begin
      n_bad++;
      $display("FAIL ill_exec: ctl=%b ill=%b want 11000 1", ctl(), illegal);
    end
    step();
    step();
    n_cmp++;
    if (op_count !== 8'd4) begin
      n_bad++;
      $display("FAIL ill_count: got %0d want 4", op_count);
    end
    start = 1'b1; opcode = 3'b011;
    step();
    start = 1'b0;
    step();
    cf_in = 1'b0; zf_in = 1'b1;
    n_cmp++;
    if (ctl() !== 5'b01010) begin
      n_bad++;
      $display("FAIL add_exec: got %b want 01010", ctl());
    end
    step();
    step();
    zf_in = 1'b0;
    n_cmp++;
    if (illegal !== 1'b1 || cf_q !== 1'b0 || zf_q !== 1'b1 ||
        op_count !== 8'd5) begin
      n_bad++;
      $display("FAIL ill_sticky: ill=%b cf=%b zf=%b cnt=%0d want 1 0 1 5",
               illegal, cf_q, zf_q, op_count);
    end
  endtask

  task automatic test_busy_start();
    int dones = 0;
    start = 1'b1; opcode = 3'b010;
    step();
    opcode = 3'b100;
    step();
    n_cmp++;
    if (ctl() !== 5'b10000) begin
      n_bad++;
      $display("FAIL busy_exec: got %b want 10000", ctl());
    end
    start = 1'b0;
    if (done) dones++;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) dones++;
    end
    n_cmp++;
    if (dones != 1 || op_count !== 8'd6) begin
      n_bad++;
      $display("FAIL busy_ignore: dones=%0d cnt=%0d want 1 6",
               dones, op_count);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; opcode = 3'b011;
    cf_in = 1'b1; zf_in = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++;
    if (Eu !== 1'b1 || nLa !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_pre: Eu=%b nLa=%b want 1 0", Eu, nLa);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (nLa !== 1'b1 || Eu !== 1'b0 || busy !== 1'b0 ||
        op_count !== 8'd0 || cf_q !== 1'b0 || zf_q !== 1'b0 ||
        illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_now: nLa=%b Eu=%b busy=%b cnt=%0d cf=%b zf=%b ill=%b",
               nLa, Eu, busy, op_count, cf_q, zf_q, illegal);
    end
    #1 rst = 1'b0;
    cf_in = 1'b0; zf_in = 1'b0;
    start = 1'b1; opcode = 3'b001;
    step();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || cf_q !== 1'b0 || op_count !== 8'd0) begin
      n_bad++;
      $display("FAIL arst_restart: busy=%b cf=%b cnt=%0d want 1 0 0",
               busy, cf_q, op_count);
    end
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int both = 0;
    int lds = 0;
    do_reset();
    start = 1'b1; opcode = 3'b011;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (done) dones++;
      if (Ea && Eu) both++;
      if (!nLa && !nLb) lds++;
      if (i == 1019) begin
        n_cmp++;
        if (op_count !== 8'd255) begin
          n_bad++;
          $display("FAIL b2b_255: got %0d want 255", op_count);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (dones != 256 || op_count !== 8'd0) begin
      n_bad++;
      $display("FAIL b2b_wrap: dones=%0d cnt=%0d want 256 0",
               dones, op_count);
    end
    n_cmp++;
    if (both != 0 || lds != 0) begin
      n_bad++;
      $display("FAIL b2b_excl: EaEu=%0d nLanLb=%0d want 0 0", both, lds);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_stop: busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sub_out();
    test_illegal();
    test_busy_start();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have the parameter OPW, default 3, opcode width in bits; values other than 3 are unsupported.
REQ-002 The block SHALL have the port clk, input, 1, rising-edge clock for all state.
REQ-003 The block SHALL have the port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have the port start, input, 1, request to execute opcode; sampled only in IDLE.
REQ-005 The block SHALL have the port opcode, input, OPW, instruction: 000 NOP, 001 LDA, 010 LDB, 011 ADD, 100 SUB, 101 OUT, 110/111 illegal.
REQ-006 The block SHALL have the ports cf_in and zf_in, input, 1 each, carry and zero flags from the adder/accumulator.
REQ-007 The block SHALL have the ports nLa and nLb, output, 1 each, active-low load strobes for registers A and B.
REQ-008 The block SHALL have the ports Ea and Eu, output, 1 each, active-high bus enables for register A and the ALU result.
REQ-009 The block SHALL have the port sub, output, 1, ALU mode: 1 subtract, 0 add.
REQ-010 The block SHALL have the ports busy, done and illegal, output, 1 each, status (see Function).
REQ-011 The block SHALL have the ports cf_q and zf_q, output, 1 each, latched flags.
REQ-012 The block SHALL have the port op_count, output, 8, count of completed instructions.

Function
REQ-013 The FSM SHALL have the states IDLE, DECODE, EXEC and DONE, one cycle each except IDLE.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL latch opcode into an internal register and go to DECODE; with start=0 it SHALL stay in IDLE.
REQ-015 DECODE SHALL always go to EXEC, EXEC SHALL always go to DONE, and DONE SHALL always go to IDLE, so start-to-done latency is 3 cycles.
REQ-016 Control outputs SHALL be registered-state decodes, and outside EXEC they SHALL be inactive: nLa=1, nLb=1, Ea=0, Eu=0, sub=0.
REQ-017 In EXEC, LDA SHALL drive nLa=0 and LDB SHALL drive nLb=0.
REQ-018 In EXEC, ADD SHALL drive Eu=1, nLa=0, sub=0, and SUB SHALL drive Eu=1, nLa=0, sub=1.
REQ-019 In EXEC, OUT SHALL drive Ea=1, and NOP and illegal opcodes SHALL drive all controls inactive.
REQ-020 Ea and Eu SHALL never be 1 in the same cycle, and nLa and nLb SHALL never be 0 in the same cycle.
REQ-021 On the edge leaving EXEC, the block SHALL capture cf_q<=cf_in and zf_q<=zf_in for ADD/SUB only; all other opcodes SHALL hold the flags.
REQ-022 busy SHALL be 1 in DECODE, EXEC and DONE, and 0 in IDLE.
REQ-023 done SHALL be 1 for exactly the DONE cycle.
REQ-024 illegal SHALL be set on the edge leaving DECODE when the latched opcode is 110 or 111, and SHALL be sticky until reset.
REQ-025 op_count SHALL increment by 1 on the edge leaving DONE, for all opcodes including illegal ones, and SHALL wrap from 255 to 0.
REQ-026 start and opcode changes while busy=1 SHALL be ignored, with no queueing.
REQ-027 start=1 held continuously SHALL issue back-to-back instructions with period 4 cycles: IDLE to DECODE on the edge after DONE.

Reset
REQ-028 rst=1 SHALL asynchronously force state=IDLE, the latched opcode to 000, and nLa=1, nLb=1, Ea=0, Eu=0, sub=0.
REQ-029 rst=1 SHALL also asynchronously force busy=0, done=0, illegal=0, cf_q=0, zf_q=0 and op_count=0.
REQ-030 rst asserted mid-instruction, including during EXEC, SHALL deassert all strobes immediately without waiting for a clock, and the aborted instruction SHALL NOT update flags or op_count.
REQ-031 After rst falls, the first start SHALL be accepted on the next rising edge.

Verification
REQ-032 The bench SHALL cover: reset, then start=1 with opcode=001 for 1 cycle -> nLa=0 exactly in cycle 3 after start (EXEC), done=1 in cycle 4, and op_count=1.
REQ-033 The bench SHALL cover: opcode=100 with cf_in=1 and zf_in=1 during EXEC -> Eu=1, sub=1, nLa=0 in EXEC, then cf_q=1 and zf_q=1 after DONE; a following OUT leaves the flags unchanged.
REQ-034 The bench SHALL cover: opcode=110 -> no strobes, illegal=1 persisting through a later valid ADD, and op_count incremented.
REQ-035 The bench SHALL cover: start held high for 1024 cycles with ADD -> 256 instructions completed, op_count wraps to 0, and Ea and Eu are never both 1.
REQ-036 The bench SHALL cover: rst pulsed asynchronously mid-EXEC of ADD -> nLa=1 and Eu=0 before the next edge, and op_count and flags are 0.
REQ-037 The bench SHALL cover: start pulsed while busy -> ignored, so only one done pulse occurs per accepted start.
